// File: rtl/bounding_box_calc_if.sv
// Video in/out and latched bounding-box bundle for bounding_box_calc.
interface bounding_box_calc_if;
   logic        de_in;
   logic        hsync_in;
   logic        vsync_in;
   logic [23:0] pixel_in;
   logic        de_out;
   logic        hsync_out;
   logic        vsync_out;
   logic [23:0] pixel_out;
   logic [10:0] left_top_x;
   logic [10:0] left_top_y;
   logic [10:0] right_bottom_x;
   logic [10:0] right_bottom_y;
   logic        box_valid;
   logic        frame_done;

   modport slave (
      input  de_in, hsync_in, vsync_in, pixel_in,
      output de_out, hsync_out, vsync_out, pixel_out,
      output left_top_x, left_top_y, right_bottom_x, right_bottom_y,
      output box_valid, frame_done
   );

   modport master (
      output de_in, hsync_in, vsync_in, pixel_in,
      input  de_out, hsync_out, vsync_out, pixel_out,
      input  left_top_x, left_top_y, right_bottom_x, right_bottom_y,
      input  box_valid, frame_done
   );
endinterface

// File: rtl/bounding_box_calc.sv
// Per-frame foreground bounding box of a binarized stream; box latched on the
// vsync rise that closes each frame, video passed through with one cycle delay.
module bounding_box_calc #(
   parameter int IMG_H      = 720,
   parameter int IMG_W      = 1280,
   parameter int MIN_PIXELS = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   bounding_box_calc_if.slave  vif
);

   typedef enum logic [1:0] {SYNC, VBLANK, ACTIVE} state_t;

   localparam logic [10:0] X_LAST  = 11'(IMG_W - 1);
   localparam logic [10:0] Y_LAST  = 11'(IMG_H - 1);
   localparam logic [19:0] CNT_MAX = '1;
   localparam logic [19:0] MIN_CNT = 20'(MIN_PIXELS);

   state_t      state, state_nxt;
   logic        vsync_d;
   logic [10:0] x_pos, y_pos;
   logic [10:0] min_x, min_y, max_x, max_y;
   logic [19:0] cnt;
   logic        rise, fg, latch, acc_clr;

   assign rise    = vif.vsync_in & ~vsync_d;
   // vsync has priority over a coincident data-enable pixel
   assign fg      = vif.de_in & ~vif.vsync_in & (vif.pixel_in != '0);
   assign acc_clr = (state != ACTIVE) | latch;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= SYNC;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      latch     = 1'b0;
      case (state)
         SYNC:    if (vif.vsync_in) state_nxt = VBLANK;
         VBLANK:  if (!vif.vsync_in) state_nxt = ACTIVE;
         ACTIVE:  if (rise) begin
                     latch     = 1'b1;
                     state_nxt = VBLANK;
                  end
         default: state_nxt = SYNC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vif.de_out    <= 1'b0;
         vif.hsync_out <= 1'b0;
         vif.vsync_out <= 1'b0;
         vif.pixel_out <= '0;
         vsync_d       <= 1'b0;
      end else begin
         vif.de_out    <= vif.de_in;
         vif.hsync_out <= vif.hsync_in;
         vif.vsync_out <= vif.vsync_in;
         vif.pixel_out <= vif.pixel_in;
         vsync_d       <= vif.vsync_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || vif.vsync_in) begin
         x_pos <= '0;
         y_pos <= '0;
      end else if (vif.de_in) begin
         if (x_pos == X_LAST) begin
            x_pos <= '0;
            y_pos <= (y_pos == Y_LAST) ? '0 : y_pos + 11'd1;
         end else begin
            x_pos <= x_pos + 11'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || acc_clr) begin
         min_x <= 11'h7FF;
         min_y <= 11'h7FF;
         max_x <= '0;
         max_y <= '0;
         cnt   <= '0;
      end else if (fg) begin
         if (x_pos < min_x) min_x <= x_pos;
         if (y_pos < min_y) min_y <= y_pos;
         if (x_pos > max_x) max_x <= x_pos;
         if (y_pos > max_y) max_y <= y_pos;
         if (cnt != CNT_MAX) cnt <= cnt + 20'd1;
      end
   end

   // Coordinates only move on a qualifying frame so they stay stable otherwise
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vif.left_top_x     <= '0;
         vif.left_top_y     <= '0;
         vif.right_bottom_x <= '0;
         vif.right_bottom_y <= '0;
         vif.box_valid      <= 1'b0;
         vif.frame_done     <= 1'b0;
      end else begin
         vif.frame_done <= latch;
         if (latch) begin
            if (cnt >= MIN_CNT) begin
               vif.left_top_x     <= min_x;
               vif.left_top_y     <= min_y;
               vif.right_bottom_x <= max_x;
               vif.right_bottom_y <= max_y;
               vif.box_valid      <= 1'b1;
            end else begin
               vif.box_valid      <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_bounding_box_calc.sv
// Scoreboard bench: two instances (MIN_PIXELS 1 and 3) share one stimulus stream.
module tb_bounding_box_calc;
   localparam int W = 8;
   localparam int H = 6;

   typedef struct {
      logic [10:0] x0, y0, x1, y1;
      logic        v;
   } box_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        de = 1'b0, hs = 1'b0, vs = 1'b0;
   logic [23:0] px = '0;

   always #5 clk = ~clk;

   bounding_box_calc_if ifa();
   bounding_box_calc_if ifb();

   assign ifa.de_in = de;  assign ifa.hsync_in = hs;  assign ifa.vsync_in = vs;  assign ifa.pixel_in = px;
   assign ifb.de_in = de;  assign ifb.hsync_in = hs;  assign ifb.vsync_in = vs;  assign ifb.pixel_in = px;

   bounding_box_calc #(.IMG_H(H), .IMG_W(W), .MIN_PIXELS(1)) dut_a (.clk(clk), .rst_n(rst_n), .vif(ifa.slave));
   bounding_box_calc #(.IMG_H(H), .IMG_W(W), .MIN_PIXELS(3)) dut_b (.clk(clk), .rst_n(rst_n), .vif(ifb.slave));

   box_t qa[$], qb[$];
   box_t hold_a, hold_b;
   bit   armed;
   bit   fg [H][W];
   int   tests = 0, fails = 0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_box(input string name, input box_t a, input box_t e);
      tests++;
      if (a.x0 !== e.x0 || a.y0 !== e.y0 || a.x1 !== e.x1 || a.y1 !== e.y1 || a.v !== e.v) begin
         fails++;
         $display("FAIL %s: got (%0d,%0d,%0d,%0d) v=%0b expected (%0d,%0d,%0d,%0d) v=%0b at %0t",
                  name, a.x0, a.y0, a.x1, a.y1, a.v, e.x0, e.y0, e.x1, e.y1, e.v, $time);
      end
   endtask

   function automatic box_t get_box(input logic [10:0] x0, y0, x1, y1, input logic v);
      box_t b;
      b.x0 = x0; b.y0 = y0; b.x1 = x1; b.y1 = y1; b.v = v;
      return b;
   endfunction

   // Pass-through reference: the inputs seen at the last edge (zeros under reset)
   logic [26:0] pd;
   bit          started = 0;
   always @(posedge clk) begin
      started <= 1'b1;
      pd      <= rst_n ? {de, hs, vs, px} : '0;
   end

   always @(negedge clk) begin
      box_t e;
      if (started) begin
         cmp("pass_a", {ifa.de_out, ifa.hsync_out, ifa.vsync_out, ifa.pixel_out}, pd);
         cmp("pass_b", {ifb.de_out, ifb.hsync_out, ifb.vsync_out, ifb.pixel_out}, pd);
      end
      if (ifa.frame_done === 1'b1) begin
         if (qa.size() == 0) cmp("unexpected_done_a", 1, 0);
         else begin
            e = qa.pop_front();
            cmp_box("box_a", get_box(ifa.left_top_x, ifa.left_top_y, ifa.right_bottom_x,
                                     ifa.right_bottom_y, ifa.box_valid), e);
         end
      end
      if (ifb.frame_done === 1'b1) begin
         if (qb.size() == 0) cmp("unexpected_done_b", 1, 0);
         else begin
            e = qb.pop_front();
            cmp_box("box_b", get_box(ifb.left_top_x, ifb.left_top_y, ifb.right_bottom_x,
                                     ifb.right_bottom_y, ifb.box_valid), e);
         end
      end
   end

   task automatic cyc(input logic d, input logic h, input logic v, input logic [23:0] p);
      de = d; hs = h; vs = v; px = p;
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      cmp({tag, "_box_a"}, {ifa.left_top_x, ifa.left_top_y, ifa.right_bottom_x, ifa.right_bottom_y,
                            ifa.box_valid, ifa.frame_done}, 0);
      cmp({tag, "_box_b"}, {ifb.left_top_x, ifb.left_top_y, ifb.right_bottom_x, ifb.right_bottom_y,
                            ifb.box_valid, ifb.frame_done}, 0);
      cmp({tag, "_pass_a"}, {ifa.de_out, ifa.hsync_out, ifa.vsync_out, ifa.pixel_out}, 0);
   endtask

   task automatic clear_fg();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) fg[y][x] = 0;
   endtask

   // hot: vsync rises together with a full-white data-enable pixel
   task automatic vsync_pulse(input bit hot);
      if (hot) cyc(1, 0, 1, 24'hFFFFFF);
      else     cyc(0, 0, 1, 24'($urandom));
      cyc(0, 0, 1, 24'($urandom));
      cyc(0, 0, 0, 24'($urandom));
      cyc(0, 0, 0, 24'($urandom));
      armed = 1;
   endtask

   task automatic push_expect(input int n, input int x0, y0, x1, y1);
      if (n >= 1) begin
         hold_a = get_box(11'(x0), 11'(y0), 11'(x1), 11'(y1), 1);
         qa.push_back(hold_a);
      end else begin
         hold_a.v = 0; qa.push_back(hold_a);
      end
      if (n >= 3) begin
         hold_b = get_box(11'(x0), 11'(y0), 11'(x1), 11'(y1), 1);
         qb.push_back(hold_b);
      end else begin
         hold_b.v = 0; qb.push_back(hold_b);
      end
   endtask

   // One active region from fg[][]; rst_line >= 0 pulses reset at that line's start
   task automatic frame(input int rst_line);
      int n, x0, y0, x1, y1;
      for (int y = 0; y < H; y++) begin
         if (y == rst_line) begin
            rst_n = 1'b0;
            cyc(0, 0, 0, 0);
            check_zero("rst_mid");
            cyc(0, 0, 0, 0);
            rst_n = 1'b1;
            armed = 0;
            hold_a = get_box(0, 0, 0, 0, 0);
            hold_b = get_box(0, 0, 0, 0, 0);
         end
         for (int x = 0; x < W; x++)
            cyc(1, 0, 0, fg[y][x] ? 24'($urandom_range(1, 24'hFFFFFF)) : 24'h0);
         cyc(0, 1, 0, 24'($urandom));
         cyc(0, 1, 0, 24'($urandom));
      end
      n = 0; x0 = W; y0 = H; x1 = -1; y1 = -1;
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            if (fg[y][x]) begin
               n++;
               if (x < x0) x0 = x;
               if (x > x1) x1 = x;
               if (y < y0) y0 = y;
               if (y > y1) y1 = y;
            end
      if (armed) push_expect(n, x0, y0, x1, y1);
   endtask

   initial begin
      int dens;
      hold_a = get_box(0, 0, 0, 0, 0);
      hold_b = get_box(0, 0, 0, 0, 0);
      armed  = 0;
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      check_zero("rst");
      rst_n = 1'b1;
      clear_fg();
      frame(-1);              // partial frame after reset, discarded
      vsync_pulse(0);

      clear_fg(); fg[2][3] = 1;                       frame(-1); vsync_pulse(0);
      clear_fg(); fg[1][1] = 1; fg[4][6] = 1;         frame(-1); vsync_pulse(0);
      clear_fg();                                     frame(-1); vsync_pulse(0);
      clear_fg(); fg[0][0] = 1; fg[5][7] = 1;         frame(-1); vsync_pulse(0);
      fg[3][4] = 1;                                   frame(-1); vsync_pulse(0);
      clear_fg(); fg[5][5] = 1;                       frame(3);  vsync_pulse(0);
      clear_fg(); fg[3][2] = 1;                       frame(-1); vsync_pulse(0);
      clear_fg();                                     frame(-1); vsync_pulse(1);

      for (int f = 0; f < 20; f++) begin
         case ($urandom_range(0, 3))
            0: dens = 0;
            1: dens = 2;
            2: dens = 6;
            default: dens = 30;
         endcase
         for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) fg[y][x] = ($urandom_range(0, 99) < dens);
         frame(-1);
         vsync_pulse(bit'($urandom_range(0, 1)));
      end

      repeat (4) cyc(0, 0, 0, 0);
      cmp("drain_a", qa.size(), 0);
      cmp("drain_b", qb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
